// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the I-cache and
// D-cache miss paths; the granted side's request and response pass straight through.
module l2_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_stb,
    input  logic              i_cyc,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    output logic              i_retry,

    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_byte_enable,
    input  logic              d_write,
    input  logic              d_stb,
    input  logic              d_cyc,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              d_retry,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_byte_enable,
    output logic              mem_write,
    output logic              mem_stb,
    output logic              mem_cyc,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    input  logic              mem_retry,

    output logic [15:0]       i_grant_count,
    output logic [15:0]       d_grant_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] i_cnt_q, i_cnt_d;
    logic [15:0] d_cnt_q, d_cnt_d;
    logic        i_pend, d_pend;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign i_pend = i_stb & i_cyc;
    assign d_pend = d_stb & d_cyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            i_cnt_q <= 16'd0;
            d_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        i_cnt_d         = i_cnt_q;
        d_cnt_d         = d_cnt_q;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        mem_write       = 1'b0;
        mem_stb         = 1'b0;
        mem_cyc         = 1'b0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        i_retry         = i_pend;
        d_retry         = d_pend;

        case (state_q)
            IDLE: begin
                // On a tie, last_q == 1 means D won last time, so I goes now.
                if (i_pend && (!d_pend || last_q)) begin
                    state_d = GRANT_I;
                    last_d  = 1'b0;
                    i_cnt_d = sat_inc(i_cnt_q);
                end else if (d_pend) begin
                    state_d = GRANT_D;
                    last_d  = 1'b1;
                    d_cnt_d = sat_inc(d_cnt_q);
                end
            end
            GRANT_I: begin
                mem_address = i_address;
                mem_stb     = i_stb;
                mem_cyc     = i_cyc;
                i_resp      = mem_resp;
                i_retry     = mem_retry;
                if (mem_resp || !i_cyc) begin
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                mem_byte_enable = d_byte_enable;
                mem_write       = d_write;
                mem_stb         = d_stb;
                mem_cyc         = d_cyc;
                d_resp          = mem_resp;
                d_retry         = mem_retry;
                if (mem_resp || !d_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_rdata       = mem_rdata;
    assign d_rdata       = mem_rdata;
    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: arbitration, round-robin, retry, abort,
// reset mid-grant and grant-counter saturation.
module tb_l2_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] i_address = '0;
    logic              i_stb = 1'b0, i_cyc = 1'b0;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp, i_retry;
    logic [ADDR_W-1:0] d_address = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [MASK_W-1:0] d_byte_enable = '0;
    logic              d_write = 1'b0, d_stb = 1'b0, d_cyc = 1'b0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp, d_retry;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_byte_enable;
    logic              mem_write, mem_stb, mem_cyc;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_resp = 1'b0, mem_retry = 1'b0;
    logic [15:0]       i_grant_count, d_grant_count;

    int tests = 0;
    int fails = 0;

    localparam logic [DATA_W-1:0] RD_A5  = {16{8'hA5}};
    localparam logic [DATA_W-1:0] WD_BE  = {8{16'hBEEF}};
    localparam logic [DATA_W-1:0] WD_123 = {4{32'h12345678}};

    l2_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_stb(i_stb), .i_cyc(i_cyc),
        .i_rdata(i_rdata), .i_resp(i_resp), .i_retry(i_retry),
        .d_address(d_address), .d_wdata(d_wdata), .d_byte_enable(d_byte_enable),
        .d_write(d_write), .d_stb(d_stb), .d_cyc(d_cyc),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_retry(d_retry),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_write(mem_write), .mem_stb(mem_stb), .mem_cyc(mem_cyc),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_retry(mem_retry),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_stb = 1'b0; i_cyc = 1'b0;
        d_stb = 1'b0; d_cyc = 1'b0; d_write = 1'b0;
        mem_resp = 1'b0; mem_retry = 1'b0;
    endtask

    // Complete whatever is granted, drop all requests, settle in IDLE.
    task automatic finish_idle();
        mem_resp = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        tests++;
        if ({mem_address, mem_wdata, mem_byte_enable, mem_write, mem_stb, mem_cyc} !== '0) begin
            fails++;
            $display("FAIL reset_mem: got stb=%0b cyc=%0b addr=%h want all zero", mem_stb, mem_cyc, mem_address);
        end
        tests++;
        if ({i_resp, d_resp, i_retry, d_retry} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_resp_retry: got %b want 0000", {i_resp, d_resp, i_retry, d_retry});
        end
        tests++;
        if ({i_grant_count, d_grant_count} !== 32'd0) begin
            fails++;
            $display("FAIL reset_counts: got i=%0d d=%0d want 0 0", i_grant_count, d_grant_count);
        end
        d_stb = 1'b1; d_cyc = 1'b1;
        #1;
        tests++;
        if ({d_retry, i_retry, mem_stb} !== 3'b100) begin
            fails++;
            $display("FAIL reset_retry_follows: got d_retry,i_retry,mem_stb=%b want 100", {d_retry, i_retry, mem_stb});
        end
        clear_inputs();
    endtask

    task automatic test_single_read();
        reset = 1'b0;
        step();
        i_address = 16'h0040; i_stb = 1'b1; i_cyc = 1'b1;
        #1;
        tests++;
        if ({i_retry, mem_stb} !== 2'b10) begin
            fails++;
            $display("FAIL read_c0: got i_retry,mem_stb=%b want 10", {i_retry, mem_stb});
        end
        step();
        tests++;
        if (mem_address !== 16'h0040 || {mem_stb, mem_cyc, mem_write, i_retry, i_resp} !== 5'b11000) begin
            fails++;
            $display("FAIL read_c1_grant: got addr=%h flags=%b want 0040 11000", mem_address, {mem_stb, mem_cyc, mem_write, i_retry, i_resp});
        end
        step();
        step();
        tests++;
        if (mem_stb !== 1'b1 || i_resp !== 1'b0) begin
            fails++;
            $display("FAIL read_c3_hold: got stb=%b resp=%b want 1 0", mem_stb, i_resp);
        end
        step();
        mem_resp = 1'b1; mem_rdata = RD_A5;
        #1;
        tests++;
        if (i_resp !== 1'b1 || i_rdata !== RD_A5 || d_rdata !== RD_A5 || d_resp !== 1'b0) begin
            fails++;
            $display("FAIL read_c4_resp: got i_resp=%b d_resp=%b i_rdata=%h want 1 0 %h", i_resp, d_resp, i_rdata, RD_A5);
        end
        step();
        mem_resp = 1'b0;
        #1;
        tests++;
        if ({mem_stb, i_retry} !== 2'b01 || i_grant_count !== 16'd1) begin
            fails++;
            $display("FAIL read_c5_idle: got stb,retry=%b count=%0d want 01 1", {mem_stb, i_retry}, i_grant_count);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_tie_round_robin();
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_address = 16'h0100; i_stb = 1'b1; i_cyc = 1'b1;
        d_address = 16'h2000; d_write = 1'b1; d_byte_enable = 16'h00FF; d_wdata = WD_BE;
        d_stb = 1'b1; d_cyc = 1'b1;
        #1;
        tests++;
        if ({i_retry, d_retry, mem_stb} !== 3'b110) begin
            fails++;
            $display("FAIL tie_idle: got i_retry,d_retry,stb=%b want 110", {i_retry, d_retry, mem_stb});
        end
        step();
        tests++;
        if (mem_address !== 16'h0100 || mem_write !== 1'b0 || mem_byte_enable !== 16'h0000 || d_retry !== 1'b1) begin
            fails++;
            $display("FAIL tie_first_i: got addr=%h wr=%b be=%h d_retry=%b want 0100 0 0000 1", mem_address, mem_write, mem_byte_enable, d_retry);
        end
        step();
        mem_resp = 1'b1;
        #1;
        tests++;
        if ({i_resp, d_resp, d_retry} !== 3'b101) begin
            fails++;
            $display("FAIL tie_i_resp: got i_resp,d_resp,d_retry=%b want 101", {i_resp, d_resp, d_retry});
        end
        step();
        mem_resp = 1'b0; i_stb = 1'b0; i_cyc = 1'b0;
        #1;
        tests++;
        if ({mem_stb, d_retry} !== 2'b01) begin
            fails++;
            $display("FAIL tie_bubble: got stb,d_retry=%b want 01", {mem_stb, d_retry});
        end
        step();
        tests++;
        if (mem_address !== 16'h2000 || mem_write !== 1'b1 || mem_byte_enable !== 16'h00FF || mem_wdata !== WD_BE || mem_stb !== 1'b1) begin
            fails++;
            $display("FAIL tie_then_d: got addr=%h wr=%b be=%h stb=%b want 2000 1 00ff 1", mem_address, mem_write, mem_byte_enable, mem_stb);
        end
        tests++;
        if (i_grant_count !== 16'd1 || d_grant_count !== 16'd1) begin
            fails++;
            $display("FAIL tie_counts: got i=%0d d=%0d want 1 1", i_grant_count, d_grant_count);
        end
        mem_resp = 1'b1; i_stb = 1'b1; i_cyc = 1'b1;
        #1;
        tests++;
        if ({d_resp, i_resp, i_retry} !== 3'b101) begin
            fails++;
            $display("FAIL tie_d_resp: got d_resp,i_resp,i_retry=%b want 101", {d_resp, i_resp, i_retry});
        end
        step();
        mem_resp = 1'b0;
        step();
        tests++;
        if (mem_address !== 16'h0100 || mem_stb !== 1'b1 || i_grant_count !== 16'd2 || d_retry !== 1'b1) begin
            fails++;
            $display("FAIL tie_rr_i_again: got addr=%h stb=%b icount=%0d d_retry=%b want 0100 1 2 1", mem_address, mem_stb, i_grant_count, d_retry);
        end
        finish_idle();
    endtask

    task automatic test_retry_hold();
        d_address = 16'h3000; d_write = 1'b1; d_byte_enable = 16'hF00F; d_wdata = WD_123;
        d_stb = 1'b1; d_cyc = 1'b1;
        step();
        mem_retry = 1'b1;
        i_address = 16'h0200; i_stb = 1'b1; i_cyc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if ({d_retry, d_resp, i_retry, i_resp, mem_stb, mem_write} !== 6'b101011 ||
                mem_address !== 16'h3000 || mem_byte_enable !== 16'hF00F || mem_wdata !== WD_123) begin
                fails++;
                $display("FAIL retry_hold_%0d: got flags=%b addr=%h be=%h want 101011 3000 f00f", k, {d_retry, d_resp, i_retry, i_resp, mem_stb, mem_write}, mem_address, mem_byte_enable);
            end
            @(posedge clk);
        end
        #1;
        mem_retry = 1'b0; mem_resp = 1'b1;
        #1;
        tests++;
        if ({d_resp, d_retry, i_resp} !== 3'b100 || d_grant_count !== 16'd2) begin
            fails++;
            $display("FAIL retry_done: got d_resp,d_retry,i_resp=%b dcount=%0d want 100 2", {d_resp, d_retry, i_resp}, d_grant_count);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_abort();
        d_address = 16'h4000; d_write = 1'b0; d_stb = 1'b1; d_cyc = 1'b1;
        step();
        i_address = 16'h0300; i_stb = 1'b1; i_cyc = 1'b1;
        step();
        tests++;
        if (mem_cyc !== 1'b1 || mem_address !== 16'h4000 || i_retry !== 1'b1) begin
            fails++;
            $display("FAIL abort_c2: got cyc=%b addr=%h i_retry=%b want 1 4000 1", mem_cyc, mem_address, i_retry);
        end
        step();
        d_stb = 1'b0; d_cyc = 1'b0;
        #1;
        tests++;
        if ({mem_cyc, mem_stb, d_resp} !== 3'b000) begin
            fails++;
            $display("FAIL abort_c3_drop: got cyc,stb,d_resp=%b want 000", {mem_cyc, mem_stb, d_resp});
        end
        step();
        tests++;
        if ({mem_stb, i_retry} !== 2'b01) begin
            fails++;
            $display("FAIL abort_c4_idle: got stb,i_retry=%b want 01", {mem_stb, i_retry});
        end
        step();
        tests++;
        if (mem_address !== 16'h0300 || {mem_stb, i_retry} !== 2'b10) begin
            fails++;
            $display("FAIL abort_c5_i_grant: got addr=%h stb,i_retry=%b want 0300 10", mem_address, {mem_stb, i_retry});
        end
        finish_idle();
    endtask

    task automatic test_reset_mid_grant();
        d_address = 16'h5000; d_write = 1'b1; d_stb = 1'b1; d_cyc = 1'b1;
        step();
        mem_retry = 1'b1;
        step();
        tests++;
        if ({mem_stb, d_retry} !== 2'b11) begin
            fails++;
            $display("FAIL rst_mid_pre: got stb,d_retry=%b want 11", {mem_stb, d_retry});
        end
        reset = 1'b1;
        step();
        tests++;
        if ({mem_stb, mem_cyc, d_resp, d_retry} !== 4'b0001 || i_grant_count !== 16'd0 || d_grant_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid_idle: got stb,cyc,resp,retry=%b i=%0d d=%0d want 0001 0 0", {mem_stb, mem_cyc, d_resp, d_retry}, i_grant_count, d_grant_count);
        end
        reset = 1'b0; mem_retry = 1'b0;
        i_address = 16'h0400; i_stb = 1'b1; i_cyc = 1'b1;
        step();
        tests++;
        if (mem_address !== 16'h0400 || i_grant_count !== 16'd1 || d_grant_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid_last_grant: got addr=%h i=%0d d=%0d want 0400 1 0", mem_address, i_grant_count, d_grant_count);
        end
        finish_idle();
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        step();
        reset = 1'b0;
        force dut.i_cnt_q = 16'hFFFF;
        i_address = 16'h0500; i_stb = 1'b1; i_cyc = 1'b1;
        step();
        finish_idle();
        release dut.i_cnt_q;
        for (int g = 0; g < 2; g++) begin
            i_stb = 1'b1; i_cyc = 1'b1;
            step();
            tests++;
            if (i_grant_count !== 16'hFFFF || d_grant_count !== 16'd0 || mem_stb !== 1'b1) begin
                fails++;
                $display("FAIL sat_grant_%0d: got i=%h d=%h stb=%b want ffff 0000 1", g, i_grant_count, d_grant_count, mem_stb);
            end
            finish_idle();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_round_robin();
        test_retry_hold();
        test_abort();
        test_reset_mid_grant();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
